// File: rtl/crossing_scheduler.sv
// Pedestrian-phase scheduler for a single-road crossing: input conditioning, road-green timing, sequencer handshake.
// Define GRANT_TIMEOUT_EN to add a grant watchdog whose sticky fault forces led=4'b1111 until rst.
module crossing_scheduler #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEB_CYCLES     = 500000,
  parameter int unsigned MIN_ROAD_GREEN = 250000000,
  parameter int unsigned MAX_EXTEND     = 500000000,
  parameter int unsigned GRANT_TIMEOUT  = 1000000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_butt,
  input  logic       road_det,
  output logic       seq_req,
  input  logic       seq_ack,
  input  logic       seq_done,
  output logic       ped_wait,
  output logic [3:0] led
);

  // State codes double as the one-hot led pattern.
  typedef enum logic [3:0] {
    ROAD_MIN  = 4'b0001,
    ROAD_IDLE = 4'b0010,
    GRANT     = 4'b0100,
    SERVE     = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ROAD_GREEN - 1);
  localparam logic [CNT_W-1:0] EXT_LAST = CNT_W'(MAX_EXTEND - 1);

  logic             butt_p0, butt_p1;
  logic             road_p0, road_p1;
  logic             deb_lvl_p2, deb_lvl_p3;
  logic [CNT_W-1:0] deb_cnt;
  logic             press;
  logic [CNT_W-1:0] road_cnt;
  logic [CNT_W-1:0] ext_cnt;
  logic             pending;
  logic             fault;
  state_t           state;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  logic [CNT_W-1:0] grant_cnt;
`else
  assign fault = 1'b0;
`endif

  // Stage p0/p1: two-flop synchronisers for the asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      butt_p0 <= 1'b0;
      butt_p1 <= 1'b0;
      road_p0 <= 1'b0;
      road_p1 <= 1'b0;
    end else begin
      butt_p0 <= ped_butt;
      butt_p1 <= butt_p0;
      road_p0 <= road_det;
      road_p1 <= road_p0;
    end
  end

  // Stage p2/p3: debounced level and its delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt    <= '0;
      deb_lvl_p2 <= 1'b0;
      deb_lvl_p3 <= 1'b0;
    end else begin
      deb_lvl_p3 <= deb_lvl_p2;
      if (butt_p1 == deb_lvl_p2) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl_p2 <= butt_p1;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end
    end
  end

  assign press = deb_lvl_p2 & ~deb_lvl_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ROAD_MIN;
      road_cnt <= '0;
      ext_cnt  <= '0;
      pending  <= 1'b0;
      seq_req  <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      grant_cnt <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      // An ack in GRANT wins over a coincident press.
      if (state == GRANT && seq_ack) begin
        pending <= 1'b0;
      end else if (press && state != SERVE) begin
        pending <= 1'b1;
      end
      if (!pending) begin
        ext_cnt <= '0;
      end
      case (state)
        ROAD_MIN: begin
          if (road_cnt == MIN_LAST) begin
            state    <= ROAD_IDLE;
            road_cnt <= '0;
          end else begin
            road_cnt <= road_cnt + CNT_ONE;
          end
        end
        ROAD_IDLE: begin
          if (pending) begin
            if (!road_p1 || ext_cnt == EXT_LAST) begin
              state   <= GRANT;
              seq_req <= 1'b1;
              ext_cnt <= '0;
`ifdef GRANT_TIMEOUT_EN
              grant_cnt <= '0;
`endif
            end else begin
              ext_cnt <= ext_cnt + CNT_ONE;
            end
          end
        end
        GRANT: begin
          if (seq_ack) begin
            state   <= SERVE;
            seq_req <= 1'b0;
          end
`ifdef GRANT_TIMEOUT_EN
          else if (grant_cnt == GRANT_LAST) begin
            state    <= ROAD_MIN;
            seq_req  <= 1'b0;
            road_cnt <= '0;
            fault    <= 1'b1;
          end else begin
            grant_cnt <= grant_cnt + CNT_ONE;
          end
`endif
        end
        SERVE: begin
          if (seq_done) begin
            state    <= ROAD_MIN;
            road_cnt <= '0;
          end
        end
        default: begin
          state    <= ROAD_MIN;
          road_cnt <= '0;
          seq_req  <= 1'b0;
        end
      endcase
    end
  end

  assign ped_wait = pending;
  assign led      = fault ? 4'b1111 : 4'(state);

endmodule

// File: tb/tb_crossing_scheduler.sv
// Self-checking bench for crossing_scheduler: per-cycle behavioural model plus directed literal checks.
// Honours GRANT_TIMEOUT_EN the same way as the design.
module tb_crossing_scheduler;
  localparam int DEB = 4;
  localparam int MIN = 20;
  localparam int MAXE = 10;
  localparam int TO  = 15;

  logic       clk = 1'b0;
  logic       rst, ped_butt, road_det, seq_ack, seq_done;
  logic       seq_req, ped_wait;
  logic [3:0] led;

  int passed = 0;
  int total  = 0;
  int n, rise_at;

  crossing_scheduler #(
    .CNT_W(32), .DEB_CYCLES(DEB), .MIN_ROAD_GREEN(MIN),
    .MAX_EXTEND(MAXE), .GRANT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .ped_butt(ped_butt), .road_det(road_det),
    .seq_req(seq_req), .seq_ack(seq_ack), .seq_done(seq_done),
    .ped_wait(ped_wait), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phases 0=road minimum, 1=road idle, 2=grant, 3=serve.
  bit m_on = 0;
  int m_b1, m_b2, m_r1, m_r2;
  int m_deb, m_run;
  bit m_rose;
  int m_ph, m_t, m_ext, m_gt;
  bit m_pend, m_req, m_fault;

  always @(posedge clk) begin
    bit press_now, old_pend;
    int bsync, rsync, ph;
    if (rst) begin
      m_on = 1;
      m_b1 = 0; m_b2 = 0; m_r1 = 0; m_r2 = 0;
      m_deb = 0; m_run = 0; m_rose = 0;
      m_ph = 0; m_t = 0; m_ext = 0; m_gt = 0;
      m_pend = 0; m_req = 0; m_fault = 0;
    end else begin
      bsync = m_b2; rsync = m_r2; ph = m_ph; old_pend = m_pend;
      press_now = m_rose;
      // debounced level follows the synchronised button after DEB consecutive disagreeing cycles
      m_rose = 0;
      if (bsync != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = bsync; m_run = 0; m_rose = (bsync == 1);
        end
      end else m_run = 0;
      m_b2 = m_b1; m_b1 = int'(ped_butt);
      m_r2 = m_r1; m_r1 = int'(road_det);
      if (ph == 2 && seq_ack) m_pend = 0;
      else if (press_now && ph != 3) m_pend = 1;
      if (!old_pend) m_ext = 0;
      case (ph)
        0: begin
          m_t++;
          if (m_t == MIN) begin m_ph = 1; m_t = 0; end
        end
        1: if (old_pend) begin
          if (rsync == 0 || m_ext == MAXE - 1) begin
            m_ph = 2; m_req = 1; m_ext = 0; m_gt = 0;
          end else m_ext++;
        end
        2: begin
          if (seq_ack) begin m_ph = 3; m_req = 0; end
`ifdef GRANT_TIMEOUT_EN
          else begin
            m_gt++;
            if (m_gt == TO) begin m_ph = 0; m_t = 0; m_req = 0; m_fault = 1; end
          end
`endif
        end
        default: if (seq_done) begin m_ph = 0; m_t = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model_seq_req", 32'(seq_req), 32'(m_req));
      check("model_ped_wait", 32'(ped_wait), 32'(m_pend));
      check("model_led", 32'(led), m_fault ? 32'd15 : 32'(1 << m_ph));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; ped_butt = 0; road_det = 0; seq_ack = 0; seq_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'b0001);
    check("reset_req", 32'(seq_req), 0);
    check("reset_wait", 32'(ped_wait), 0);

    // Held press: latency DEB+3, ROAD_MIN for MIN cycles, then IDLE, then GRANT
    rst = 0; ped_butt = 1; rise_at = 0;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 8) ped_butt = 0;
      if (ped_wait && rise_at == 0) rise_at = i;
      if (i == 19) check("t1_min_led", 32'(led), 32'b0001);
      if (i == 20) check("t1_idle_led", 32'(led), 32'b0010);
    end
    check("t1_press_latency", 32'(rise_at), 7);
    check("t1_grant_led", 32'(led), 32'b0100);
    check("t1_grant_req", 32'(seq_req), 1);

    // Ack, ignored press in SERVE, done, press in new ROAD_MIN
    seq_ack = 1; tick(); seq_ack = 0;
    check("t4_ack_req", 32'(seq_req), 0);
    check("t4_ack_wait", 32'(ped_wait), 0);
    check("t4_serve_led", 32'(led), 32'b1000);
    ped_butt = 1; repeat (8) tick(); ped_butt = 0; repeat (8) tick();
    check("t4_serve_press_ignored", 32'(ped_wait), 0);
    seq_done = 1; tick(); seq_done = 0;
    check("t4_done_led", 32'(led), 32'b0001);
    ped_butt = 1; n = 0;
    while (!seq_req && n < 100) begin
      tick(); n++;
      if (n == 8) ped_butt = 0;
      if (n == 10) check("t4_min_press", 32'(ped_wait), 1);
    end
    check("t4_regrant_delay", 32'(n), 21);

    // Reset mid-handshake
    rst = 1; tick();
    check("t5_rst_req", 32'(seq_req), 0);
    check("t5_rst_wait", 32'(ped_wait), 0);
    check("t5_rst_led", 32'(led), 32'b0001);
    rst = 0;

    // Short bounce produces no press
    repeat (20) tick();
    ped_butt = 1; repeat (3) tick(); ped_butt = 0; repeat (10) tick();
    check("t2_bounce_wait", 32'(ped_wait), 0);
    check("t2_bounce_led", 32'(led), 32'b0010);

    // Vehicle present throughout: extension bounded by MAX_EXTEND
    road_det = 1; repeat (3) tick();
    ped_butt = 1; n = 0;
    while (!ped_wait && n < 30) begin tick(); n++; end
    check("t3_press_latency", 32'(n), 7);
    ped_butt = 0; n = 0;
    while (!seq_req && n < 50) begin tick(); n++; end
    check("t3_extend_max", 32'(n), 10);
    seq_ack = 1; tick(); seq_ack = 0;
    repeat (2) tick();
    seq_done = 1; tick(); seq_done = 0;
    repeat (21) tick();
    check("t3_idle_led", 32'(led), 32'b0010);

    // Vehicle leaves after 4 cycles of pending
    ped_butt = 1; n = 0;
    while (!ped_wait && n < 30) begin tick(); n++; end
    ped_butt = 0; n = 0;
    while (!seq_req && n < 50) begin
      tick(); n++;
      if (n == 4) road_det = 0;
    end
    check("t3_extend_drop", 32'(n), 7);

`ifdef GRANT_TIMEOUT_EN
    n = 0;
    while (seq_req && n < 60) begin tick(); n++; end
    check("t6_timeout_cycles", 32'(n), 15);
    check("t6_fault_led", 32'(led), 32'b1111);
    check("t6_pending_kept", 32'(ped_wait), 1);
    n = 0;
    while (!seq_req && n < 60) begin tick(); n++; end
    check("t6_regrant_delay", 32'(n), 21);
    check("t6_fault_sticky", 32'(led), 32'b1111);
`else
    repeat (40) tick();
    check("t6_no_timeout_req", 32'(seq_req), 1);
    check("t6_no_timeout_led", 32'(led), 32'b0100);
    check("t6_no_timeout_wait", 32'(ped_wait), 1);
`endif
    rst = 1; tick(); rst = 0;
    check("final_rst_led", 32'(led), 32'b0001);
    check("final_rst_req", 32'(seq_req), 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
